// File: rtl/adc_sar_seq_pkg.sv
// Shared types and width helpers for the multi-channel SAR sequencer.
package adc_sar_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_SETTLE       = 3'd1,
    S_SAMPLE       = 3'd2,
    S_EXTRA_SAMPLE = 3'd3,
    S_BIT          = 3'd4,
    S_ACC          = 3'd5,
    S_PUSH         = 3'd6
  } state_e;

  function automatic int unsigned ch_w(input int unsigned ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  function automatic int unsigned avg_w(input int unsigned avg_max);
    return (avg_max > 0) ? $clog2(avg_max + 1) : 1;
  endfunction

  function automatic int unsigned acc_w(input int unsigned n, input int unsigned avg_max);
    return n + avg_max;
  endfunction

endpackage

// File: rtl/adc_sar_seq_sched.sv
// Channel scheduler: lowest masked channel, next masked channel above cur_i, and wrap.
module adc_sar_seq_sched #(
  parameter int unsigned CH   = 4,
  parameter int unsigned CH_W = 2
) (
  input  logic [CH-1:0]   mask_i,
  input  logic [CH_W-1:0] cur_i,
  output logic [CH_W-1:0] first_o,
  output logic [CH_W-1:0] next_o,
  output logic            last_o
);

  logic [CH_W-1:0] next_up;

  always_comb begin
    first_o = '0;
    next_up = '0;
    last_o  = 1'b1;
    // Descending scan so the lowest qualifying index is the one that sticks.
    for (int i = CH - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        first_o = CH_W'(i);
        if (i > int'(cur_i)) begin
          next_up = CH_W'(i);
          last_o  = 1'b0;
        end
      end
    end
    next_o = last_o ? first_o : next_up;
  end

endmodule

// File: rtl/aio_blk_latch.sv
// Scan-safe blocking latch in front of the analog macro; holds outputs while en_i is low.
module aio_blk_latch #(
  parameter int unsigned W = 8
) (
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_latch begin
    if (!rst_ni) begin
      q_o = '0;
    end else if (en_i) begin
      q_o = d_i;
    end
  end

endmodule

// File: rtl/dff_resync.sv
// Two-flop synchroniser for a single asynchronous level.
module dff_resync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/adc_sar_seq.sv
// Multi-channel SAR ADC sequencer: scans masked channels, averages 2^k conversions per
// channel and hands results out through a valid/ready register.
module adc_sar_seq
  import adc_sar_seq_pkg::*;
#(
  parameter int unsigned N       = 10,
  parameter int unsigned CH      = 4,
  parameter int unsigned AVG_MAX = 3,
  parameter int unsigned SETTLE  = 2,
  localparam int unsigned CH_W   = ch_w(CH),
  localparam int unsigned AVG_W  = avg_w(AVG_MAX)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             chain_scanen,
  input  logic             enable,
  input  logic             extra_sample,
  input  logic             continuous,
  input  logic [CH-1:0]    ch_mask,
  input  logic [AVG_W-1:0] avg_log2,
  input  logic             soc,
  output logic             busy,
  output logic             eoc_it,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CH_W-1:0]  res_ch,
  output logic [N-1:0]     res_data,
  input  logic             ms_rdy,
  input  logic             ms_cmp,
  output logic [CH_W-1:0]  ms_ch,
  output logic             ms_sample,
  output logic [N-1:0]     ms_dac,
  output logic             ms_clk
);

  localparam int unsigned ACC_W = acc_w(N, AVG_MAX);
  localparam int unsigned CNT_W = AVG_MAX + 1;
  localparam int unsigned BIT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned LAT_W = 2 + CH_W + N;

  state_e           state_q, state_d;
  logic [CH-1:0]    mask_q, mask_d;
  logic [AVG_W-1:0] avg_q, avg_d;
  logic             cont_q, cont_d;
  logic             extra_q, extra_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [N-1:0]     code_q, code_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_valid_q, res_valid_d;
  logic [CH_W-1:0]  res_ch_q, res_ch_d;
  logic [N-1:0]     res_data_q, res_data_d;
  logic             eoc_q, eoc_d;

  logic             rdy_s;
  logic             cmp_l;
  logic [CH-1:0]    sched_mask;
  logic [CH_W-1:0]  sched_first, sched_next;
  logic             sched_last;
  logic [AVG_W-1:0] avg_sat;
  logic [N-1:0]     bit_mask, trial;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_inc, cnt_target;
  logic             soc_ok, sampling;
  logic [LAT_W-1:0] lat_d, lat_q;

  dff_resync u_rdy_sync (
    .clk_i  (clk),
    .rst_ni (rstb),
    .d_i    (ms_rdy),
    .q_o    (rdy_s)
  );

  // Comparator is sampled during the low phase so it is stable at the rising edge.
  always_latch begin
    if (!clk) begin
      cmp_l = ms_cmp;
    end
  end

  assign sched_mask = (state_q == S_IDLE) ? ch_mask : mask_q;

  adc_sar_seq_sched #(
    .CH   (CH),
    .CH_W (CH_W)
  ) u_sched (
    .mask_i  (sched_mask),
    .cur_i   (ch_q),
    .first_o (sched_first),
    .next_o  (sched_next),
    .last_o  (sched_last)
  );

  assign avg_sat    = (32'(avg_log2) > AVG_MAX) ? AVG_W'(AVG_MAX) : avg_log2;
  assign bit_mask   = N'(1) << bit_q;
  assign trial      = (state_q == S_BIT) ? (code_q | bit_mask) : code_q;
  assign acc_sum    = acc_q + ACC_W'(code_q);
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign cnt_target = CNT_W'(1) << avg_q;
  assign soc_ok     = soc & enable & (|ch_mask) & (state_q == S_IDLE);
  assign sampling   = (state_q == S_SAMPLE) | (state_q == S_EXTRA_SAMPLE);

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    avg_d       = avg_q;
    cont_d      = cont_q;
    extra_d     = extra_q;
    ch_d        = ch_q;
    settle_d    = settle_q;
    bit_d       = bit_q;
    code_d      = code_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q & ~res_ready;
    res_ch_d    = res_ch_q;
    res_data_d  = res_data_q;
    eoc_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (soc_ok) begin
          mask_d   = ch_mask;
          avg_d    = avg_sat;
          cont_d   = continuous;
          extra_d  = extra_sample;
          ch_d     = sched_first;
          settle_d = SET_W'(SETTLE - 1);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      S_SAMPLE: begin
        if (rdy_s) begin
          code_d  = '0;
          bit_d   = BIT_W'(N - 1);
          state_d = extra_q ? S_EXTRA_SAMPLE : S_BIT;
        end
      end
      S_EXTRA_SAMPLE: state_d = S_BIT;
      S_BIT: begin
        code_d = cmp_l ? trial : code_q;
        if (bit_q == '0) begin
          state_d = S_ACC;
        end else begin
          bit_d = bit_q - BIT_W'(1);
        end
      end
      S_ACC: begin
        acc_d   = acc_sum;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc < cnt_target) ? S_SAMPLE : S_PUSH;
      end
      S_PUSH: begin
        if (!res_valid_q || res_ready) begin
          res_valid_d = 1'b1;
          res_data_d  = N'(acc_q >> avg_q);
          res_ch_d    = ch_q;
          acc_d       = '0;
          cnt_d       = '0;
          if (sched_last && !cont_q) begin
            state_d = S_IDLE;
            eoc_d   = 1'b1;
          end else begin
            ch_d = sched_next;
            // Same channel again (single-channel wrap) needs no mux settling.
            if (sched_next == ch_q) begin
              state_d = S_SAMPLE;
            end else begin
              state_d  = S_SETTLE;
              settle_d = SET_W'(SETTLE - 1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!enable) begin
      state_d     = S_IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      res_valid_d = 1'b0;
      eoc_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      avg_q       <= '0;
      cont_q      <= 1'b0;
      extra_q     <= 1'b0;
      ch_q        <= '0;
      settle_q    <= '0;
      bit_q       <= '0;
      code_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_data_q  <= '0;
      eoc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      avg_q       <= avg_d;
      cont_q      <= cont_d;
      extra_q     <= extra_d;
      ch_q        <= ch_d;
      settle_q    <= settle_d;
      bit_q       <= bit_d;
      code_q      <= code_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_data_q  <= res_data_d;
      eoc_q       <= eoc_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign eoc_it    = eoc_q;
  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_data  = res_data_q;

  // Sampling switch is active low towards the macro.
  assign lat_d = {clk, ~sampling, ch_q, trial};

  aio_blk_latch #(
    .W (LAT_W)
  ) u_aio_latch (
    .rst_ni (rstb),
    .en_i   (~chain_scanen),
    .d_i    (lat_d),
    .q_o    (lat_q)
  );

  assign ms_clk    = lat_q[LAT_W-1];
  assign ms_sample = lat_q[LAT_W-2];
  assign ms_ch     = lat_q[N +: CH_W];
  assign ms_dac    = lat_q[N-1:0];

endmodule
